// File: rtl/spi_pkg.sv
// Shared SPI link definitions used by both ends of the output-only master / receive-only slave pair.
// Idle levels double as synchroniser reset values, so reset cannot fabricate an edge.
package spi_pkg;

  localparam logic SPI_SCK_IDLE  = 1'b1;
  localparam logic SPI_CS_IDLE   = 1'b1;
  localparam logic SPI_MOSI_IDLE = 1'b1;
  localparam logic SPI_LSB_FIRST = 1'b1;

  typedef struct packed {
    logic rise;
    logic cs_fall;
    logic cs_rise;
  } spi_evt_t;

endpackage

// File: rtl/spi_slave_in_if.sv
// Pin-side SPI signals plus the parallel word bus of the receive-only slave.
interface spi_slave_in_if #(
  parameter int BITS = 4
);
  logic            sck;
  logic            cs;
  logic            mosi;
  logic [BITS-1:0] out_buf;
  logic            valid;
  logic            frame_err;
  logic            busy;

  modport master (
    output sck, cs, mosi,
    input  out_buf, valid, frame_err, busy
  );

  modport slave (
    input  sck, cs, mosi,
    output out_buf, valid, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_in_sync2.sv
// Two-flop synchroniser for one asynchronous pin; resets to the pin's idle level.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;
endmodule

// File: rtl/spi_slave_in.sv
// Receive-only SPI slave: oversamples SCK/CS/MOSI in clk, assembles BITS-bit words,
// strobes valid on each complete word and frame_err on a CS rise mid-word.
module spi_slave_in
  import spi_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  spi_slave_in_if.slave bus
);
  localparam int            CW   = ($clog2(BITS) > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  logic            w_sck_s;
  logic            w_cs_s;
  logic            w_mosi_s;
  logic            r_sck_prev;
  logic            r_cs_prev;
  logic [CW-1:0]   r_cnt;
  logic [BITS-2:0] r_sh;
  logic [BITS-2:0] w_sh_next;
  logic [BITS-1:0] w_word;
  logic [BITS-1:0] r_out_buf;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_busy;
  logic            w_take;
  spi_evt_t        w_evt;

  sync2 #(.RESET_VAL(SPI_SCK_IDLE)) u_sync_sck (
    .clk(clk), .reset(reset), .d(bus.sck), .q(w_sck_s)
  );
  sync2 #(.RESET_VAL(SPI_CS_IDLE)) u_sync_cs (
    .clk(clk), .reset(reset), .d(bus.cs), .q(w_cs_s)
  );
  sync2 #(.RESET_VAL(SPI_MOSI_IDLE)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(bus.mosi), .q(w_mosi_s)
  );

  always_comb begin
    w_evt         = '0;
    w_evt.rise    = w_sck_s & ~r_sck_prev;
    w_evt.cs_fall = ~w_cs_s & r_cs_prev;
    w_evt.cs_rise = w_cs_s & ~r_cs_prev;
  end

  // A rise landing in the same cycle as the CS rise still belongs to the frame.
  assign w_take = w_evt.rise & (~w_cs_s | ~r_cs_prev);

  if (SPI_LSB_FIRST) begin : g_lsb
    assign w_word = {w_mosi_s, r_sh};
    if (BITS == 2) begin : g_sh_min
      assign w_sh_next = w_mosi_s;
    end else begin : g_sh_wide
      assign w_sh_next = {w_mosi_s, r_sh[BITS-2:1]};
    end
  end else begin : g_msb
    assign w_word = {r_sh, w_mosi_s};
    if (BITS == 2) begin : g_sh_min
      assign w_sh_next = w_mosi_s;
    end else begin : g_sh_wide
      assign w_sh_next = {r_sh[BITS-3:0], w_mosi_s};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_prev  <= SPI_SCK_IDLE;
      r_cs_prev   <= SPI_CS_IDLE;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_out_buf   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_sck_prev  <= w_sck_s;
      r_cs_prev   <= w_cs_s;
      r_busy      <= ~w_cs_s;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_evt.cs_fall) begin
        r_cnt <= '0;
      end else if (w_take) begin
        if (r_cnt == LAST) begin
          r_out_buf <= w_word;
          r_valid   <= 1'b1;
          r_cnt     <= '0;
        end else if (w_evt.cs_rise) begin
          r_frame_err <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_evt.cs_rise && (r_cnt != '0)) begin
        r_frame_err <= 1'b1;
        r_cnt       <= '0;
      end
    end
  end

  assign bus.out_buf   = r_out_buf;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_spi_slave_in.sv
// Bench for spi_slave_in: 4-bit and 5-bit instances share one driven SPI link; expected
// words and framing errors come from chopping the transmitted bit stream into BITS-sized groups.
module tb_spi_slave_in;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b1;
  logic cs = 1'b1;
  logic mosi = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got4[$];
  logic [7:0] got5[$];
  int         ferr4 = 0;
  int         ferr5 = 0;
  logic [7:0] exp4[$];
  logic [7:0] exp5[$];
  int         eferr4 = 0;
  int         eferr5 = 0;
  bit         tx_bits[$];

  always #5 clk = ~clk;

  spi_slave_in_if #(.BITS(4)) if4 ();
  spi_slave_in_if #(.BITS(5)) if5 ();

  assign if4.sck  = sck;
  assign if4.cs   = cs;
  assign if4.mosi = mosi;
  assign if5.sck  = sck;
  assign if5.cs   = cs;
  assign if5.mosi = mosi;

  spi_slave_in #(.BITS(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  spi_slave_in #(.BITS(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));

  // Pulse monitor: collects every strobe seen outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (if4.valid)     got4.push_back(8'(if4.out_buf));
      if (if5.valid)     got5.push_back(8'(if5.out_buf));
      if (if4.frame_err) ferr4 = ferr4 + 1;
      if (if5.frame_err) ferr5 = ferr5 + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] peek(input int which, input int idx);
    if (which == 4) return (idx < got4.size()) ? got4[idx] : 8'hxx;
    return (idx < got5.size()) ? got5[idx] : 8'hxx;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit b, input int h);
    sck  = 1'b0;
    mosi = b;
    wait_clk(h);
    sck  = 1'b1;
  endtask

  task automatic load_word(input logic [7:0] w, input int nb);
    for (int k = 0; k < nb; k++) tx_bits.push_back(w[k]);
  endtask

  task automatic clear_expect();
    exp4.delete();
    exp5.delete();
    eferr4 = 0;
    eferr5 = 0;
  endtask

  // Reference: every complete BITS-bit group is a word (first bit = LSB); a leftover is an error.
  task automatic model_expect();
    int n = tx_bits.size();
    for (int b = 4; b <= 5; b++) begin
      for (int w = 0; w < n / b; w++) begin
        int v = 0;
        for (int k = 0; k < b; k++) v += int'(tx_bits[w*b+k]) << k;
        if (b == 4) exp4.push_back(8'(v));
        else        exp5.push_back(8'(v));
      end
      if (n % b != 0) begin
        if (b == 4) eferr4++;
        else        eferr5++;
      end
    end
  endtask

  task automatic send_frame(input int h, input bit coincide);
    cs = 1'b0;
    wait_clk(h);
    for (int i = 0; i < tx_bits.size(); i++) begin
      drive_bit(tx_bits[i], h);
      if (coincide && i == tx_bits.size() - 1) cs = 1'b1;
      wait_clk(h);
    end
    cs   = 1'b1;
    mosi = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(3);
    n_checks++; if (if4.out_buf !== 4'h0) begin n_errors++; $display("FAIL reset_out_buf4: got %h want 0", if4.out_buf); end
    n_checks++; if (if4.valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid4: got %b want 0", if4.valid); end
    n_checks++; if (if4.frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_ferr4: got %b want 0", if4.frame_err); end
    n_checks++; if (if4.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy4: got %b want 0", if4.busy); end
    n_checks++; if (if5.out_buf !== 5'h00) begin n_errors++; $display("FAIL reset_out_buf5: got %h want 0", if5.out_buf); end
    n_checks++; if (if5.valid !== 1'b0 || if5.frame_err !== 1'b0 || if5.busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags5: got v=%b fe=%b busy=%b want 0", if5.valid, if5.frame_err, if5.busy);
    end
    reset = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_full_word();
    int s4 = got4.size();
    int f4 = ferr4;
    cs = 1'b0;
    wait_clk(3);
    drive_bit(1'b0, 3);
    wait_clk(3);
    n_checks++; if (if4.busy !== 1'b1) begin n_errors++; $display("FAIL full_busy_mid: got %b want 1", if4.busy); end
    drive_bit(1'b1, 3); wait_clk(3);
    drive_bit(1'b0, 3); wait_clk(3);
    drive_bit(1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (if4.valid !== 1'b0) begin n_errors++; $display("FAIL full_valid_early: got %b want 0 after E+1", if4.valid); end
    @(negedge clk);
    n_checks++; if (if4.valid !== 1'b1 || if4.out_buf !== 4'hA) begin
      n_errors++; $display("FAIL full_valid_E2: got v=%b out=%h want v=1 out=a", if4.valid, if4.out_buf);
    end
    @(negedge clk);
    n_checks++; if (if4.valid !== 1'b0) begin n_errors++; $display("FAIL full_valid_width: got %b want 0 after E+3", if4.valid); end
    n_checks++; if (if4.busy !== 1'b1) begin n_errors++; $display("FAIL full_busy_end: got %b want 1", if4.busy); end
    cs   = 1'b1;
    mosi = 1'b1;
    wait_clk(4);
    n_checks++; if (if4.busy !== 1'b0) begin n_errors++; $display("FAIL full_busy_after: got %b want 0", if4.busy); end
    n_checks++; if (got4.size() - s4 !== 1 || peek(4, s4) !== 8'h0A) begin
      n_errors++; $display("FAIL full_word: got %0d words first=%h want 1 word 0a", got4.size() - s4, peek(4, s4));
    end
    n_checks++; if (ferr4 - f4 !== 0) begin n_errors++; $display("FAIL full_ferr: got %0d want 0", ferr4 - f4); end
  endtask

  task automatic test_back_to_back();
    int s4 = got4.size();
    int f4 = ferr4;
    clear_expect();
    tx_bits.delete(); load_word(8'h3, 4); model_expect(); send_frame(3, 1'b0);
    tx_bits.delete(); load_word(8'hC, 4); model_expect(); send_frame(3, 1'b0);
    n_checks++; if (got4.size() - s4 !== exp4.size()) begin
      n_errors++; $display("FAIL b2b_count: got %0d words want %0d", got4.size() - s4, exp4.size());
    end
    foreach (exp4[k]) begin
      n_checks++; if (peek(4, s4 + k) !== exp4[k]) begin
        n_errors++; $display("FAIL b2b_word%0d: got %h want %h", k, peek(4, s4 + k), exp4[k]);
      end
    end
    n_checks++; if (ferr4 - f4 !== eferr4) begin n_errors++; $display("FAIL b2b_ferr: got %0d want %0d", ferr4 - f4, eferr4); end
  endtask

  task automatic test_truncated();
    int s4 = got4.size();
    int f4 = ferr4;
    clear_expect();
    tx_bits.delete(); load_word(8'h1, 2); model_expect(); send_frame(3, 1'b0);
    n_checks++; if (ferr4 - f4 !== eferr4 || got4.size() != s4) begin
      n_errors++; $display("FAIL trunc_pulses: got ferr=%0d words=%0d want ferr=%0d words=0", ferr4 - f4, got4.size() - s4, eferr4);
    end
    n_checks++; if (if4.out_buf !== 4'hC) begin n_errors++; $display("FAIL trunc_hold: got %h want c", if4.out_buf); end
    tx_bits.delete(); load_word(8'h5, 4); model_expect(); send_frame(3, 1'b0);
    n_checks++; if (got4.size() - s4 !== exp4.size()) begin
      n_errors++; $display("FAIL trunc_count: got %0d words want %0d", got4.size() - s4, exp4.size());
    end
    foreach (exp4[k]) begin
      n_checks++; if (peek(4, s4 + k) !== exp4[k]) begin
        n_errors++; $display("FAIL trunc_word%0d: got %h want %h", k, peek(4, s4 + k), exp4[k]);
      end
    end
    n_checks++; if (ferr4 - f4 !== eferr4) begin n_errors++; $display("FAIL trunc_ferr: got %0d want %0d", ferr4 - f4, eferr4); end
  endtask

  task automatic test_continuous();
    int s4 = got4.size();
    int f4 = ferr4;
    clear_expect();
    tx_bits.delete(); load_word(8'h1, 4); load_word(8'hE, 4); model_expect(); send_frame(3, 1'b0);
    n_checks++; if (got4.size() - s4 !== exp4.size()) begin
      n_errors++; $display("FAIL cont_count: got %0d words want %0d", got4.size() - s4, exp4.size());
    end
    foreach (exp4[k]) begin
      n_checks++; if (peek(4, s4 + k) !== exp4[k]) begin
        n_errors++; $display("FAIL cont_word%0d: got %h want %h", k, peek(4, s4 + k), exp4[k]);
      end
    end
    n_checks++; if (ferr4 - f4 !== eferr4) begin n_errors++; $display("FAIL cont_ferr: got %0d want %0d", ferr4 - f4, eferr4); end
  endtask

  task automatic test_noise();
    int s4 = got4.size();
    int f4 = ferr4;
    clear_expect();
    for (int i = 0; i < 10; i++) begin
      drive_bit(1'($urandom), 3);
      wait_clk(3);
    end
    mosi = 1'b1;
    wait_clk(4);
    n_checks++; if (got4.size() != s4 || ferr4 != f4) begin
      n_errors++; $display("FAIL noise_pulses: got words=%0d ferr=%0d want 0 0", got4.size() - s4, ferr4 - f4);
    end
    tx_bits.delete(); load_word(8'h6, 4); model_expect(); send_frame(3, 1'b0);
    tx_bits.delete(); load_word(8'hB, 4); model_expect(); send_frame(3, 1'b1);
    n_checks++; if (got4.size() - s4 !== exp4.size()) begin
      n_errors++; $display("FAIL noise_count: got %0d words want %0d", got4.size() - s4, exp4.size());
    end
    foreach (exp4[k]) begin
      n_checks++; if (peek(4, s4 + k) !== exp4[k]) begin
        n_errors++; $display("FAIL noise_word%0d: got %h want %h", k, peek(4, s4 + k), exp4[k]);
      end
    end
    n_checks++; if (ferr4 - f4 !== eferr4) begin n_errors++; $display("FAIL coincide_ferr: got %0d want %0d", ferr4 - f4, eferr4); end
  endtask

  task automatic test_reset_midframe();
    for (int r = 0; r < 2; r++) begin
      int s4;
      int s5;
      int f4;
      int f5;
      cs = 1'b0;
      wait_clk(3);
      drive_bit(1'b1, 3); wait_clk(3);
      drive_bit(1'b1, 3); wait_clk(3);
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (if4.out_buf !== 4'h0 || if4.valid !== 1'b0 || if4.frame_err !== 1'b0 || if4.busy !== 1'b0) begin
        n_errors++; $display("FAIL rst_mid4_r%0d: got out=%h v=%b fe=%b busy=%b want all 0", r, if4.out_buf, if4.valid, if4.frame_err, if4.busy);
      end
      n_checks++; if (if5.out_buf !== 5'h0 || if5.valid !== 1'b0 || if5.frame_err !== 1'b0 || if5.busy !== 1'b0) begin
        n_errors++; $display("FAIL rst_mid5_r%0d: got out=%h v=%b fe=%b busy=%b want all 0", r, if5.out_buf, if5.valid, if5.frame_err, if5.busy);
      end
      wait_clk(2);
      cs   = 1'b1;
      sck  = 1'b1;
      mosi = 1'b1;
      wait_clk(2);
      s4 = got4.size(); s5 = got5.size(); f4 = ferr4; f5 = ferr5;
      reset = 1'b0;
      wait_clk(5);
      n_checks++; if (got4.size() != s4 || got5.size() != s5 || ferr4 != f4 || ferr5 != f5) begin
        n_errors++; $display("FAIL rst_mid_pulses_r%0d: got spurious strobes after release", r);
      end
      clear_expect();
      tx_bits.delete();
      if (r == 0) load_word(8'h09, 4);
      else        load_word(8'h15, 5);
      model_expect();
      send_frame(3, 1'b0);
      n_checks++; if (got4.size() - s4 !== exp4.size() || (exp4.size() > 0 && peek(4, s4) !== exp4[0])) begin
        n_errors++; $display("FAIL rst_after4_r%0d: got %0d words first=%h want %0d", r, got4.size() - s4, peek(4, s4), exp4.size());
      end
      n_checks++; if (got5.size() - s5 !== exp5.size() || (exp5.size() > 0 && peek(5, s5) !== exp5[0])) begin
        n_errors++; $display("FAIL rst_after5_r%0d: got %0d words first=%h want %0d", r, got5.size() - s5, peek(5, s5), exp5.size());
      end
      n_checks++; if (ferr4 - f4 !== eferr4 || ferr5 - f5 !== eferr5) begin
        n_errors++; $display("FAIL rst_after_ferr_r%0d: got %0d/%0d want %0d/%0d", r, ferr4 - f4, ferr5 - f5, eferr4, eferr5);
      end
    end
  endtask

  task automatic test_random();
    int s4 = got4.size();
    int s5 = got5.size();
    int f4 = ferr4;
    int f5 = ferr5;
    clear_expect();
    for (int f = 0; f < 16; f++) begin
      int nb = int'($urandom_range(13, 1));
      int h  = int'($urandom_range(5, 3));
      tx_bits.delete();
      for (int i = 0; i < nb; i++) tx_bits.push_back(1'($urandom));
      model_expect();
      send_frame(h, 1'($urandom));
    end
    n_checks++; if (got4.size() - s4 !== exp4.size()) begin
      n_errors++; $display("FAIL rand_count4: got %0d words want %0d", got4.size() - s4, exp4.size());
    end
    foreach (exp4[k]) begin
      n_checks++; if (peek(4, s4 + k) !== exp4[k]) begin
        n_errors++; $display("FAIL rand4_word%0d: got %h want %h", k, peek(4, s4 + k), exp4[k]);
      end
    end
    n_checks++; if (got5.size() - s5 !== exp5.size()) begin
      n_errors++; $display("FAIL rand_count5: got %0d words want %0d", got5.size() - s5, exp5.size());
    end
    foreach (exp5[k]) begin
      n_checks++; if (peek(5, s5 + k) !== exp5[k]) begin
        n_errors++; $display("FAIL rand5_word%0d: got %h want %h", k, peek(5, s5 + k), exp5[k]);
      end
    end
    n_checks++; if (ferr4 - f4 !== eferr4 || ferr5 - f5 !== eferr5) begin
      n_errors++; $display("FAIL rand_ferr: got %0d/%0d want %0d/%0d", ferr4 - f4, ferr5 - f5, eferr4, eferr5);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_truncated();
    test_continuous();
    test_noise();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_in.md
# spi_slave_in

Receive-only SPI slave that deserialises words sent by the team's output-only SPI master (CS active-low, SCK idle-high, MOSI launched on SCK fall, LSB first). It oversamples SCK/CS/MOSI in the local `clk` domain, assembles `BITS`-bit words and presents each one on a registered parallel bus with a one-cycle `valid` strobe. It also flags frames truncated by early CS deassertion. It sits at the chip pins on the consumer side of the link, e.g. feeding setpoints or coefficients into the PID core.

## Interface
- `BITS`, default 4: word width; must be ≥ 2; any value allowed.
- `clk`  in  1  system clock. SCK half-period must be ≥ 3 `clk` cycles.
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `sck`  in  1  SPI clock, asynchronous to `clk`; idles high.
- `cs`  in  1  chip select, active-low, asynchronous.
- `mosi`  in  1  serial data, asynchronous; sampled on SCK rise.
- `out_buf`  out  BITS  last complete word, LSB = first bit received; holds until the next word completes.
- `valid`  out  1  one-cycle pulse when `out_buf` updates.
- `frame_err`  out  1  one-cycle pulse when CS rises with a partial word.
- `busy`  out  1  high while the synchronised CS is low.

## Operation
- Input conditioning: each of `sck`, `cs` and `mosi` passes through a 2-flop synchroniser.
  - Synchroniser reset levels are `sck`=1, `cs`=1, `mosi`=1 (idle), so no edge is detected out of reset.
  - A third register on `sck` and `cs` holds each one's previous synchronised value.
- Events, all taken on synchronised signals:
  - `rise` = sck_s & !sck_prev
  - `cs_fall` = !cs_s & cs_prev
  - `cs_rise` = cs_s & !cs_prev
- Bit counter `cnt`:
  - Width max(1, $clog2(BITS)); range 0..BITS-1.
  - Shift register `sh`: BITS-1 bits.
- On `rise` while cs_s=0:
  - If cnt < BITS-1: sh <= {mosi_s, sh[BITS-2:1]}, right shift with the new bit entering at the MSB; cnt <= cnt+1.
  - If cnt == BITS-1: out_buf <= {mosi_s, sh}; valid <= 1; cnt <= 0.
- `rise` while cs_s=1: ignored.
- Continuous framing: more than BITS edges within one CS-low period starts a new word. No error is raised.
- On `cs_fall`: cnt <= 0, and `sh` is don't-care.
- On `cs_rise` with cnt != 0: frame_err <= 1 and cnt <= 0. `out_buf` is unchanged.
- On `cs_rise` with cnt == 0: no action.
- Simultaneous events: `rise` completing a word in the same cycle as `cs_rise` gives `valid`=1 and `frame_err`=0. Completion takes priority.
- `busy` = !cs_s, registered.
- Reset values: `out_buf`=0, `valid`=0, `frame_err`=0, `busy`=0, cnt=0, sh=0.
- Reset mid-frame discards the partial word. No pulses are emitted.

## Timing
- Synchroniser latency is 2 `clk` edges. Event detection is combinational on sync outputs; output registration adds 1 edge.
- Let E be the `clk` edge that first captures raw SCK high on the final bit. Then:
  - `valid` and the new `out_buf` are visible after edge E+2.
  - `valid` is high for exactly one cycle and deasserts after edge E+3.
- `frame_err` uses the same latency, measured from the `clk` edge that first captures raw CS high.
- `busy` rises or falls 3 edges after the raw CS transition.
- MOSI must be stable for ≥ 1 `clk` period either side of the SCK rise. The master guarantees this by launching MOSI on SCK fall.
- Minimum word spacing is set by the SCK rate. There is no backpressure: the consumer must take `out_buf` on `valid`.

## Structure
- Sub-module `sync2`:
  - Two-flop synchroniser with parameter `RESET_VAL`, reset synchronous.
  - Instantiated three times.
- Shared package `spi_pkg`:
  - `SPI_SCK_IDLE` = 1'b1, `SPI_CS_IDLE` = 1'b1, `SPI_MOSI_IDLE` = 1'b1.
  - `SPI_LSB_FIRST` = 1'b1.
  - Used by both master and slave.
- Counter width is computed locally from `BITS`.

## Test plan
- Full word: BITS=4, master sends 4'hA (LSB first 0,1,0,1), half-period 3 clk → one `valid` pulse, `out_buf`=4'hA, `frame_err`=0, `busy` high throughout the frame.
- Back-to-back: two frames 4'h3 then 4'hC, separated by 4 clk of CS high → two `valid` pulses with `out_buf` 4'h3 then 4'hC.
- Truncated frame: CS low, 2 SCK edges, CS high → `frame_err` pulse, no `valid`, `out_buf` retains its previous value; the next full 4'h5 frame decodes correctly.
- Continuous: 8 SCK edges in one CS-low period carrying 4'h1, 4'hE → two `valid` pulses, values 4'h1 and 4'hE, no `frame_err`.
- Noise immunity: SCK toggles with CS high → no `valid`, cnt stays 0. Last-bit rise coincident with CS rise → `valid`=1, `frame_err`=0.
- Reset mid-frame: assert `reset` after 2 bits → all outputs 0 next cycle, no pulses. After release, a 4'h9 frame is received correctly. Repeat with BITS=5 sending 5'h15.
